// File: rtl/imm_ext_pkg.sv
// Shared definitions for the immediate extender: mode encodings and the legality check.
package imm_ext_pkg;

  localparam int MODE_W = 3;

  typedef enum logic [MODE_W-1:0] {
    ZERO  = 3'd0,
    SIGN  = 3'd1,
    UPPER = 3'd2,
    BROFF = 3'd3
  } mode3_t;

  // Codes 4-7 are reserved; only the low half of the code space is legal.
  function automatic logic is_legal_mode(input logic [MODE_W-1:0] mode);
    return (mode[MODE_W-1] == 1'b0);
  endfunction

endpackage

// File: rtl/imm_ext_fifo.sv
// Generic synchronous FIFO, any DEPTH >= 1; the read port shows the head entry, or the
// most recently popped entry when empty, so a drained FIFO keeps its output steady.
module imm_ext_fifo #(
  parameter int W     = 33,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [W-1:0]               push_data,
  input  logic                       pop,
  output logic [W-1:0]               rd_data,
  output logic                       empty,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [PTR_W-1:0] LAST_PTR = PTR_W'(DEPTH - 1);

  logic [W-1:0]     mem_q [DEPTH];
  logic [W-1:0]     mem_d [DEPTH];
  logic [PTR_W-1:0] wptr_q, wptr_d;
  logic [PTR_W-1:0] rptr_q, rptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [W-1:0]     last_q, last_d;

  function automatic logic [PTR_W-1:0] ptr_next(input logic [PTR_W-1:0] p);
    return (p == LAST_PTR) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    mem_d  = mem_q;
    wptr_d = wptr_q;
    rptr_d = rptr_q;
    cnt_d  = cnt_q;
    last_d = last_q;
    if (push) begin
      mem_d[wptr_q] = push_data;
      wptr_d        = ptr_next(wptr_q);
    end
    if (pop) begin
      last_d = mem_q[rptr_q];
      rptr_d = ptr_next(rptr_q);
    end
    case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Control state and the held output value clear asynchronously; storage does not.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      last_q <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      last_q <= last_d;
    end
  end

  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  assign empty   = (cnt_q == '0);
  assign count   = cnt_q;
  assign rd_data = empty ? last_q : mem_q[rptr_q];

endmodule

// File: rtl/imm_ext_unit.sv
// Buffered immediate extender: combinational mode mux feeding a small result FIFO
// with valid/ready on both sides, between instruction decode and the ALU operand mux.
module imm_ext_unit
  import imm_ext_pkg::*;
#(
  parameter int IN_W  = 16,
  parameter int OUT_W = 32,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       in_valid,
  output logic                       in_ready,
  input  logic [IN_W-1:0]            in_imm,
  input  logic [MODE_W-1:0]          in_mode,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [OUT_W-1:0]           out_imm,
  output logic                       out_err,
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

  // Returns {err, operand}; illegal modes yield a zero operand with err set.
  function automatic logic [OUT_W:0] extend(input logic [IN_W-1:0]   imm,
                                            input logic [MODE_W-1:0] mode);
    logic signed [OUT_W-1:0] sext;
    logic        [OUT_W:0]   res;
    sext = {{(OUT_W-IN_W){imm[IN_W-1]}}, imm};
    res  = {1'b1, {OUT_W{1'b0}}};
    if (is_legal_mode(mode)) begin
      case (mode3_t'(mode))
        ZERO:    res = {1'b0, {(OUT_W-IN_W){1'b0}}, imm};
        SIGN:    res = {1'b0, sext};
        UPPER:   res = {1'b0, imm, {(OUT_W-IN_W){1'b0}}};
        BROFF:   res = {1'b0, sext <<< 2};
        default: res = {1'b1, {OUT_W{1'b0}}};
      endcase
    end
    return res;
  endfunction

  logic [OUT_W:0] ext_entry;
  logic [OUT_W:0] head_entry;
  logic           fifo_empty;
  logic           push;
  logic           pop;

  assign ext_entry = extend(in_imm, in_mode);

  // A pop in the same cycle frees a slot, hence the out_ready term.
  assign in_ready  = ~rst & ((count < DEPTH_C) | out_ready);
  assign out_valid = ~fifo_empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;

  imm_ext_fifo #(
    .W     (OUT_W + 1),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (ext_entry),
    .pop       (pop),
    .rd_data   (head_entry),
    .empty     (fifo_empty),
    .count     (count)
  );

  assign {out_err, out_imm} = head_entry;

endmodule
